// File: rtl/gf_div_pkg.sv
// Shared types and constants for the sequential integer / GF(2) divider.
package gf_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OPT_INT = 1'b0;
  localparam logic OPT_GF  = 1'b1;

  // Bit-counter width: enough to count the 2W dividend bits.
  function automatic int cnt_w(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/gf_seq_divider_lead_one.sv
// Leading-one detector: keeps only the most significant set bit of the input.
module gf_lead_one #(
  parameter int W = 4
) (
  input  logic [W-1:0] in_v,
  output logic [W-1:0] onehot
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < W; i++) begin
      if (in_v[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf_seq_divider.sv
// Radix-2 sequential divider: unsigned restoring division or carry-less
// GF(2) polynomial division, one dividend bit per cycle, MSB first.
module gf_seq_divider
  import gf_div_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gf_option,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]     divisor,
  output logic                      busy,
  output logic                      done,
  output logic                      div_by_zero,
  output logic [2*DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]     remainder
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_w(DATA_WIDTH);

  state_e          state_q, state_d;
  logic [2*W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic            gf_q, gf_d;
  logic [W-1:0]    mask_q, mask_d;
  logic [W:0]      r_q, r_d;
  logic [2*W-1:0]  quot_q, quot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dbz_q, dbz_d;

  logic [W-1:0]    lead;
  logic [W:0]      r_sh;
  logic            hit;
  logic            accept;

  gf_lead_one #(.W(W)) u_lead (
    .in_v   (divisor),
    .onehot (lead)
  );

  assign accept = start && (state_q == IDLE || state_q == DONE);

  // Next-state and datapath: accept/load, one shift-subtract step per RUN cycle.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    gf_d    = gf_q;
    mask_d  = mask_q;
    r_d     = r_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    r_sh    = {r_q[W-1:0], dvd_q[2*W-1]};
    hit     = 1'b0;

    if (accept) begin
      dvd_d  = dividend;
      dvs_d  = divisor;
      gf_d   = gf_option;
      mask_d = (gf_option == OPT_GF) ? lead : '0;
      r_d    = '0;
      quot_d = '0;
      cnt_d  = CW'(2*W-1);
      dbz_d  = 1'b0;
      if (divisor == '0) begin
        // No iterations: report saturated quotient and pass low bits through.
        state_d = DONE;
        quot_d  = '1;
        r_d     = {1'b0, dividend[W-1:0]};
        dbz_d   = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (gf_q == OPT_GF) begin
        // R has degree below deg D, so bit deg D alone decides the step.
        hit = |(r_sh & {1'b0, mask_q});
        r_d = hit ? (r_sh ^ {1'b0, dvs_q}) : r_sh;
      end else begin
        hit = (r_sh >= {1'b0, dvs_q});
        r_d = hit ? (r_sh - {1'b0, dvs_q}) : r_sh;
      end
      quot_d = {quot_q[2*W-2:0], hit};
      dvd_d  = {dvd_q[2*W-2:0], 1'b0};
      if (cnt_q == '0) state_d = DONE;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      gf_q    <= 1'b0;
      mask_q  <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      gf_q    <= gf_d;
      mask_q  <= mask_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = r_q[W-1:0];

endmodule

// File: tb/tb_gf_seq_divider.sv
// Directed bench for gf_seq_divider (W=4): hand-computed vectors plus
// multiply/divide round trips in both modes.
module tb_gf_seq_divider;

  logic       clk;
  logic       rst;
  logic       gf_option;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  gf_seq_divider #(.DATA_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .gf_option   (gf_option),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Carry-less product of two 4-bit polynomials.
  function automatic logic [7:0] clmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (8'(a) << i);
    return p;
  endfunction

  // Presents one request for a single edge; lat counts edges including the
  // accepting edge until done is seen (bounded).
  task automatic do_div(input logic g, input logic [7:0] dd, input logic [3:0] ds,
                        output int l);
    @(negedge clk);
    gf_option = g; dividend = dd; divisor = ds; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; gf_option = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_q",    32'(quotient), 0);
    chk("reset_r",    32'(remainder), 0);
    chk("reset_dbz",  32'(div_by_zero), 0);
    @(negedge clk); rst = 1'b0;

    // GF 120 / 10 = 12 r 0
    do_div(1'b1, 8'd120, 4'd10, lat);
    chk("gf120_lat", 32'(lat), 9);
    chk("gf120_q", 32'(quotient), 12);
    chk("gf120_r", 32'(remainder), 0);
    chk("gf120_busy_at_done", 32'(busy), 0);
    @(posedge clk); #1;
    chk("done_single_cycle", 32'(done), 0);
    chk("hold_q_idle", 32'(quotient), 12);

    // 75 / 13 in both modes
    do_div(1'b1, 8'd75, 4'd13, lat);
    chk("gf75_q", 32'(quotient), 15);
    chk("gf75_r", 32'(remainder), 0);
    do_div(1'b0, 8'd75, 4'd13, lat);
    chk("int75_lat", 32'(lat), 9);
    chk("int75_q", 32'(quotient), 5);
    chk("int75_r", 32'(remainder), 10);

    do_div(1'b0, 8'd195, 4'd13, lat);
    chk("int195_q", 32'(quotient), 15);
    chk("int195_r", 32'(remainder), 0);
    do_div(1'b0, 8'd255, 4'd1, lat);
    chk("int255_q", 32'(quotient), 255);
    chk("int255_r", 32'(remainder), 0);
    do_div(1'b1, 8'd255, 4'd1, lat);
    chk("gf255_q", 32'(quotient), 255);

    // Divide by zero
    do_div(1'b0, 8'h5A, 4'd0, lat);
    chk("dbz_lat", 32'(lat), 1);
    chk("dbz_flag", 32'(div_by_zero), 1);
    chk("dbz_q", 32'(quotient), 255);
    chk("dbz_r", 32'(remainder), 10);
    @(posedge clk); #1;
    chk("dbz_held", 32'(div_by_zero), 1);
    @(negedge clk);
    gf_option = 1'b0; dividend = 8'd100; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dbz_cleared", 32'(div_by_zero), 0);
    chk("accept_busy", 32'(busy), 1);
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("int100_lat", 32'(lat), 9);
    chk("int100_q", 32'(quotient), 14);
    chk("int100_r", 32'(remainder), 2);

    // Start pulsed while busy is ignored
    @(negedge clk);
    gf_option = 1'b0; dividend = 8'd200; divisor = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    gf_option = 1'b1; dividend = 8'd17; divisor = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("ignore_q", 32'(quotient), 22);
    chk("ignore_r", 32'(remainder), 2);
    @(posedge clk); #1;
    chk("ignore_no_rerun", 32'(busy), 0);

    // Back-to-back: start held through DONE
    @(negedge clk);
    gf_option = 1'b0; dividend = 8'd50; divisor = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    dividend = 8'd99; divisor = 4'd11; gf_option = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_first_lat", 32'(lat), 9);
    chk("b2b_first_q", 32'(quotient), 8);
    chk("b2b_first_r", 32'(remainder), 2);
    chk("b2b_gap", 32'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rebusy", 32'(busy), 1);
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_second_lat", 32'(lat), 9);
    chk("b2b_second_q", 32'(quotient), 9);
    chk("b2b_second_r", 32'(remainder), 0);

    // Reset in the 4th RUN cycle
    @(negedge clk);
    gf_option = 1'b1; dividend = 8'd120; divisor = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    lat = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    chk("no_done_after_abort", 32'(lat), 0);
    do_div(1'b1, 8'd120, 4'd10, lat);
    chk("post_rst_lat", 32'(lat), 9);
    chk("post_rst_q", 32'(quotient), 12);
    chk("post_rst_r", 32'(remainder), 0);

    // Random multiply/divide round trips
    for (int k = 0; k < 6; k++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(1, 15));
      do_div(1'b0, 8'(a) * 8'(b), b, lat);
      chk("rt_int_q", 32'(quotient), 32'(a));
      chk("rt_int_r", 32'(remainder), 0);
      do_div(1'b1, clmul(a, b), b, lat);
      chk("rt_gf_q", 32'(quotient), 32'(a));
      chk("rt_gf_r", 32'(remainder), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gf_seq_divider.md
# gf_seq_divider

Sequential divider for the multiplier-comparison datapath. It undoes what the multipliers produce. A 2·DATA_WIDTH-bit dividend, such as a product `out`, is divided by a DATA_WIDTH-bit divisor, returning quotient and remainder. The divider works in one of two modes:
- integer mode: unsigned restoring division;
- GF mode: carry-less division of GF(2) polynomials.

It sits beside the multiplier top so benches can round-trip `a*b / b == a`.

## Interface
- DATA_WIDTH, 4, operand width W; dividend and quotient are 2W bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- gf_option  in  1  0 = unsigned integer division, 1 = GF(2) polynomial division; sampled with start
- start  in  1  request; accepted only when busy==0
- dividend  in  2W  dividend, sampled on the accepting edge
- divisor  in  W  divisor, sampled on the accepting edge
- busy  out  1  division in progress
- done  out  1  single-cycle pulse: results valid
- div_by_zero  out  1  divisor was 0; valid with done, held until the next accept
- quotient  out  2W  quotient
- remainder  out  W  remainder

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset forces IDLE and clears all outputs and internal registers to 0.
- Accepting edge: rising clk with start=1 in IDLE or DONE.
  - Latches operands and gf_option.
  - Clears the partial remainder R (W+1 bits) and the quotient register.
  - Loads the bit counter with 2W-1.
- Divisor 0 on accept: go straight to DONE with quotient = all ones, remainder = dividend[W-1:0], div_by_zero=1.
- Otherwise go to RUN. On entering RUN:
  - In GF mode, latch a one-hot mask M = leading set bit of divisor (deg D).
- Each RUN edge consumes one dividend bit, MSB first. First form R' = {R[W-1:0], next dividend bit}. Then:
  - integer mode: if R' ≥ {0,D}, then R ← R' − D and the quotient bit is 1; else R ← R' and the quotient bit is 0.
  - GF mode: if (R' & {0,M}) ≠ 0, then R ← R' XOR {0,D} and the quotient bit is 1; else R ← R' and the quotient bit is 0. Because R's degree is below deg D, testing bit deg D is exact.
  - The quotient bit is shifted in at the LSB of the quotient register.
- Invariant: R < D (integer mode) or deg R < deg D (GF mode) after every iteration, so R[W] is 0 after every step.
- When the counter reaches 0 the edge goes to DONE. remainder = R[W-1:0].
- DONE lasts one cycle. The next edge goes to IDLE, or back to RUN/DONE if start=1.
- Outputs hold their values until the next accepting edge, which clears div_by_zero.
- start while busy=1 is ignored: no queueing, no error flag.
- Changing gf_option or the operands mid-operation has no effect.

## Timing
- busy=1 exactly while state is RUN: 2W cycles, i.e. 8 for W=4.
- done=1 only in DONE. It appears 2W+1 edges after the accepting edge (9 for W=4), or 1 edge after it for a divide by zero.
- Back-to-back: start held high in the DONE cycle is accepted. The busy gap is then exactly one cycle.
- Reset asserted mid-RUN aborts immediately and asynchronously:
  - busy, done, quotient, remainder and div_by_zero all go to 0;
  - no done pulse is produced for the aborted operation.
- Outputs are all registered; there are no combinational paths from input to output.

## Structure
- Package gf_div_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode constants OPT_INT=0 and OPT_GF=1;
  - a helper constant for the counter width, clog2(2W).
- Sub-module gf_lead_one: combinational leading-one detector, W-bit input to W-bit one-hot output. It is used for the GF mask and is reusable by a future inverter.
- All other logic stays in a single always block plus next-state logic.

## Test plan
- W=4, gf_option=1, dividend=120, divisor=10 -> done 9 edges after accept, quotient=12, remainder=0 (carry-less 12·10=120).
- gf_option=1, dividend=75, divisor=13 -> quotient=15, remainder=0. Then gf_option=0 with the same operands -> quotient=5, remainder=10.
- gf_option=0, dividend=195, divisor=13 -> quotient=15, remainder=0. Then dividend=255, divisor=1 -> quotient=255, remainder=0.
- divisor=0, dividend=0x5A -> done 1 edge after accept, div_by_zero=1, quotient=255, remainder=10. The next accepted start clears div_by_zero.
- Pulse start again during busy with different operands -> ignored, and the original result is delivered. Hold start through DONE -> second operation accepted with a one-cycle busy gap.
- Assert rst at the 4th RUN cycle -> all outputs read 0 before the next clock edge, with no done pulse. After release, a new division completes correctly. A random round-trip of multiplier output divided by b equals a, remainder 0, in both modes.
